serial_char_rx: RTL

- Upstream feeder for the character-recognition Moore machine.
- Deserialises a framed serial bit stream (start 0, 8 data bits MSB first, stop 1) into 8-bit character codes on `caractere`.
- `caractere` drives the machine's 8-bit `entrada` input directly.
- Between characters, `caractere` rests at the neutral code C0 (8'b10000000), which causes no state transition downstream.
- Each received character is presented for a bounded number of clocks and is then withdrawn.

---
 rtl/serial_char_rx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/serial_char_rx.sv
// serial_char_rx: framed serial deserialiser feeding character codes to the recogniser.
// Optional SERIAL_CHAR_RX_FILTER_EN: only C1..C8 are presented, others pulse char_err.
module serial_char_rx #(
    parameter logic [7:0]  IDLE_CODE   = 8'b1000_0000,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] caractere,
    output logic       char_valid,
    output logic       frame_err,
    output logic       overrun,
`ifdef SERIAL_CHAR_RX_FILTER_EN
    output logic       char_err,
`endif
    output logic [7:0] char_count
);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_STOP,
        RX_PRESENT
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

    state_t     state;
    state_t     state_nx;
    logic [7:0] shreg;
    logic [7:0] shreg_nx;
    logic [2:0] bcnt;
    logic [2:0] bcnt_nx;
    logic [3:0] hold;
    logic [3:0] hold_nx;
    logic [7:0] car_nx;
    logic       cv_nx;
    logic       fe_nx;
    logic       ov_nx;
    logic [7:0] cnt_nx;
    logic       start_bit;
    logic       hold_last;
    logic       char_ok;

    assign start_bit = bit_valid & ~bit_in;
    assign hold_last = (hold <= 4'd1);

`ifdef SERIAL_CHAR_RX_FILTER_EN
    logic ce_nx;

    // Accept only the eight character codes the recogniser understands.
    always_comb begin
        char_ok = 1'b0;
        unique case (shreg)
            8'hF8, 8'hC0, 8'hDC, 8'hEA,
            8'hCE, 8'hF1, 8'hD5, 8'hE3: char_ok = 1'b1;
            default:                    char_ok = 1'b0;
        endcase
    end
`else
    assign char_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RX_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; a start bit while presenting begins a new frame at once.
    always_comb begin
        state_nx = state;
        unique case (state)
            RX_IDLE: begin
                if (start_bit) state_nx = RX_DATA;
            end
            RX_DATA: begin
                if (bit_valid && bcnt == 3'd7) state_nx = RX_STOP;
            end
            RX_STOP: begin
                if (bit_valid) begin
                    if (bit_in && char_ok) state_nx = RX_PRESENT;
                    else                   state_nx = RX_IDLE;
                end
            end
            RX_PRESENT: begin
                if (start_bit)      state_nx = RX_DATA;
                else if (hold_last) state_nx = RX_IDLE;
            end
            default: state_nx = RX_IDLE;
        endcase
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        shreg_nx = shreg;
        bcnt_nx  = bcnt;
        hold_nx  = hold;
        car_nx   = caractere;
        cv_nx    = char_valid;
        fe_nx    = 1'b0;
        ov_nx    = 1'b0;
        cnt_nx   = char_count;
`ifdef SERIAL_CHAR_RX_FILTER_EN
        ce_nx    = 1'b0;
`endif
        unique case (state)
            RX_IDLE: begin
                if (start_bit) bcnt_nx = 3'd0;
            end
            RX_DATA: begin
                if (bit_valid) begin
                    shreg_nx = {shreg[6:0], bit_in};
                    bcnt_nx  = bcnt + 3'd1;
                end
            end
            RX_STOP: begin
                if (bit_valid) begin
                    if (bit_in && char_ok) begin
                        car_nx  = shreg;
                        cv_nx   = 1'b1;
                        cnt_nx  = char_count + 8'd1;
                        hold_nx = HOLD_INIT;
                    end else if (bit_in) begin
`ifdef SERIAL_CHAR_RX_FILTER_EN
                        ce_nx = 1'b1;
`endif
                    end else begin
                        fe_nx = 1'b1;
                    end
                end
            end
            RX_PRESENT: begin
                if (start_bit) begin
                    ov_nx   = 1'b1;
                    car_nx  = IDLE_CODE;
                    cv_nx   = 1'b0;
                    bcnt_nx = 3'd0;
                    hold_nx = 4'd0;
                end else if (hold_last) begin
                    car_nx  = IDLE_CODE;
                    cv_nx   = 1'b0;
                    hold_nx = 4'd0;
                end else begin
                    hold_nx = hold - 4'd1;
                end
            end
            default: begin
                car_nx = IDLE_CODE;
                cv_nx  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset drops any partial character.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= 8'd0;
            bcnt       <= 3'd0;
            hold       <= 4'd0;
            caractere  <= IDLE_CODE;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            char_count <= 8'd0;
`ifdef SERIAL_CHAR_RX_FILTER_EN
            char_err   <= 1'b0;
`endif
        end else begin
            shreg      <= shreg_nx;
            bcnt       <= bcnt_nx;
            hold       <= hold_nx;
            caractere  <= car_nx;
            char_valid <= cv_nx;
            frame_err  <= fe_nx;
            overrun    <= ov_nx;
            char_count <= cnt_nx;
`ifdef SERIAL_CHAR_RX_FILTER_EN
            char_err   <= ce_nx;
`endif
        end
    end

endmodule
